// File: rtl/instr_stream_aligner.sv
// Carves variable-length, LSB-aligned instructions out of a packed stream of memory words.
// An instruction completed by an accepted word is valid one cycle later; word_ready depends only on registered fill.
module instr_stream_aligner #(
    parameter int WORD_L   = 64,
    parameter int INSTR_L  = 160,
    parameter int OPCODE_L = 4,
    parameter int LEN_W    = $clog2(INSTR_L + 1),
    parameter int BUF_L    = INSTR_L + WORD_L,
    parameter int CNT_W    = $clog2(BUF_L + 1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [(2**OPCODE_L)*LEN_W-1:0]     len_cfg,
    input  logic [WORD_L-1:0]                  word_in,
    input  logic                               word_valid,
    output logic                               word_ready,
    output logic [INSTR_L-1:0]                 instr_out,
    output logic [OPCODE_L-1:0]                instr_opcode,
    output logic                               instr_valid,
    input  logic                               instr_ready,
    input  logic                               flush,
    output logic                               err,
    output logic [CNT_W-1:0]                   fill,
    output logic [31:0]                        instr_cnt
);

    localparam logic [CNT_W-1:0] OPC_C   = CNT_W'(OPCODE_L);
    localparam logic [CNT_W-1:0] INSTR_C = CNT_W'(INSTR_L);
    localparam logic [CNT_W-1:0] WORD_C  = CNT_W'(WORD_L);

    logic [BUF_L-1:0]    bits_q, bits_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic [31:0]         icnt_q, icnt_d;

    logic [OPCODE_L-1:0] head_op;
    logic [LEN_W-1:0]    len;
    logic [CNT_W-1:0]    len_c;
    logic                has_op, len_ok, active, pop, push;

    assign head_op = bits_q[OPCODE_L-1:0];
    assign len     = len_cfg[int'(head_op)*LEN_W +: LEN_W];
    assign len_c   = CNT_W'(len);
    assign has_op  = cnt_q >= OPC_C;
    assign len_ok  = (len_c != '0) && (len_c <= INSTR_C);
    assign active  = !rst && !flush && !err_q;

    assign instr_valid = active && has_op && len_ok && (cnt_q >= len_c);
    // Once more than INSTR_L bits are held a whole legal instruction is present, so refusing words here cannot deadlock.
    assign word_ready  = active && (cnt_q <= INSTR_C);
    assign pop         = instr_valid && instr_ready;
    assign push        = word_valid && word_ready;

    always_comb begin
        instr_out = '0;
        for (int i = 0; i < INSTR_L; i++) begin
            if (has_op && (i < int'(len))) begin
                instr_out[i] = bits_q[i];
            end
        end
    end

    assign instr_opcode = instr_out[OPCODE_L-1:0];

    always_comb begin
        bits_d = bits_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        icnt_d = icnt_q;
        if (flush) begin
            bits_d = '0;
            cnt_d  = '0;
            err_d  = 1'b0;
        end else begin
            if (has_op && !len_ok) begin
                err_d = 1'b1;
            end
            if (pop) begin
                bits_d = bits_q >> len;
                cnt_d  = cnt_q - len_c;
                icnt_d = icnt_q + 32'd1;
            end
            // The incoming word lands just above whatever survives this cycle's pop.
            if (push) begin
                bits_d = bits_d | (BUF_L'(word_in) << cnt_d);
                cnt_d  = cnt_d + WORD_C;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bits_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
            icnt_q <= '0;
        end else begin
            bits_q <= bits_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
            icnt_q <= icnt_d;
        end
    end

    assign fill      = cnt_q;
    assign err       = err_q;
    assign instr_cnt = icnt_q;

endmodule
